wash_sequencer: RTL and testbench
=================================

# wash_sequencer

Parametrised wash-program sequencer for the washing-machine controller. It replaces the fixed wash/rinse/dry control with one engine that supports a programmable rinse count, water-level-scaled fill and drain times, pause/resume, a door-open interlock and a timed completion beep. It sits between the synchronised button and switch inputs and the display/LED view logic. It consumes a one-cycle seconds tick and drives the actuator and status outputs.

## Interface
- TIME_W, 8: width of the per-phase seconds counter and of the duration inputs.
- RINSE_W, 2: width of the rinse-count input and counter.
- MAX_RINSE, 3: rinse-count ceiling; larger requests are clipped to this value.
- FILL_S, 4: fill seconds per water level.
- DRAIN_S, 3: drain seconds per water level.
- SPIN_S, 5: spin seconds.
- BEEP_S, 3: duration of the DONE beep in seconds.

Ports:
- clk  in  1  system clock; one clock domain.
- resetBtn  in  1  synchronous, active-low reset.
- tick  in  1  one-cycle pulse, once per second.
- runBtn  in  1  one-cycle pulse that starts, pauses or resumes the program.
- doorOpen  in  1  level input; 1 means the door is open.
- waterLevel  in  2  water level 1..3; the value 0 is treated as 1.
- rinseCount  in  RINSE_W  number of rinse passes requested.
- washTime  in  TIME_W  WASH phase duration in seconds.
- rinseTime  in  TIME_W  RINSE phase duration in seconds.
- phase  out  3  current phase: 0 IDLE, 1 FILL, 2 WASH, 3 RINSE, 4 DRAIN, 5 SPIN, 6 DONE.
- paused  out  1  1 while the program is suspended.
- remaining  out  TIME_W  seconds left in the current phase.
- rinseLeft  out  RINSE_W  rinse passes still to run.
- valveIn, valveOut, motorWash, motorSpin  out  1 each  actuator drives.
- doorLock  out  1  door lock drive.
- beep  out  1  high during DONE.
- done  out  1  one-cycle pulse on entry to DONE.

## Operation
- Start: in IDLE, runBtn with doorOpen=0 does the following.
  - Latches the effective level L = max(waterLevel, 1).
  - Latches washTime and rinseTime.
  - Sets rinseLeft = min(rinseCount, MAX_RINSE) and clears the internal washDone flag.
  - Enters FILL.
- In IDLE, runBtn with doorOpen=1 is ignored.
- Phase durations, loaded into `remaining` on phase entry:
  - FILL = FILL_S·L
  - WASH = washTime
  - RINSE = rinseTime
  - DRAIN = DRAIN_S·L
  - SPIN = SPIN_S
  - DONE = BEEP_S
  - Products are computed at TIME_W+2 bits and saturate to 2^TIME_W−1.
- Phase sequence:
  - FILL → WASH if washDone=0, otherwise FILL → RINSE.
  - WASH → DRAIN; washDone is set on leaving WASH.
  - RINSE → DRAIN.
  - DRAIN → SPIN.
  - SPIN → if rinseLeft>0: decrement rinseLeft and go to FILL; otherwise go to DONE.
  - DONE → IDLE.
- Actuators (all forced to 0 while paused, and in IDLE and DONE):
  - valveIn = FILL
  - motorWash = WASH or RINSE
  - valveOut = DRAIN or SPIN
  - motorSpin = SPIN
- doorLock = 1 in phases FILL..SPIN, including while paused. It is 0 in IDLE and DONE.
- Pause:
  - runBtn while running in FILL..SPIN sets paused.
  - doorOpen=1 while running also sets paused.
  - runBtn while paused and doorOpen=0 clears paused. The phase and `remaining` are preserved.
  - runBtn while paused and doorOpen=1 is ignored.
- DONE ignores runBtn and doorOpen. It counts BEEP_S ticks, then returns to IDLE.
- beep = 1 exactly while phase = DONE.

## Timing
- Reset (resetBtn=0 at a clk edge), from any state:
  - phase=IDLE, paused=0, remaining=0, rinseLeft=0.
  - All actuators 0, doorLock=0, beep=0, done=0.
  - washDone=0.
- Start takes effect on the edge after runBtn: phase=FILL and remaining=FILL_S·L on that cycle.
- Countdown: on a tick while running (not paused, phase ≠ IDLE):
  - If remaining > 1: decrement by 1.
  - Otherwise: advance to the next phase and load its duration on the same edge.
- Zero-duration phase (for example washTime=0): the phase advances on the next clk edge without waiting for a tick. It lasts exactly one cycle.
- done pulses on the cycle phase first becomes DONE.
- Simultaneous events:
  - runBtn and tick on the same cycle while running: the pause wins and the tick is dropped.
  - runBtn and tick on the same cycle while paused: resume wins and the tick is dropped.
  - A tick while paused or in IDLE is ignored.
- doorOpen rising while running: paused=1 and actuators are 0 on the next cycle.
- Changing the configuration inputs after start has no effect until the next start.

## Test plan
- L=2, rinseCount=1, washTime=6, rinseTime=4, door closed, runBtn once. The phase sequence is:
  1. FILL for 8 ticks
  2. WASH for 6
  3. DRAIN for 6
  4. SPIN for 5
  5. FILL for 8
  6. RINSE for 4
  7. DRAIN for 6
  8. SPIN for 5
  9. DONE for 3 with beep=1 and one done pulse
  10. IDLE

  Total: 51 ticks.
- Pause and resume in WASH at remaining=3: runBtn gives paused=1, motorWash=0, doorLock=1. Ticks are ignored. A second runBtn resumes at remaining=3.
- Door interlock:
  - doorOpen=1 during FILL forces paused=1 and valveIn=0.
  - runBtn with the door still open leaves paused=1.
  - Close the door, then runBtn resumes the program.
- Edge configurations:
  - waterLevel=0 behaves exactly as L=1.
  - rinseCount=3 with MAX_RINSE=2 gives rinseLeft=2.
  - washTime=0: WASH lasts one cycle.
- Reset mid-RINSE with resetBtn=0 for one edge: all outputs are at their reset values on the next cycle. A subsequent start reruns the full program from WASH.
- runBtn and tick on the same cycle during SPIN at remaining=2: the program pauses and remaining stays 2.

Source files
------------

// File: rtl/wash_sequencer.sv
// Wash-program sequencer: FILL/WASH/RINSE/DRAIN/SPIN/DONE engine driven by a seconds tick,
// with pause/resume, door interlock, programmable rinse passes and level-scaled fill/drain.
module wash_sequencer #(
  parameter int TIME_W    = 8,
  parameter int RINSE_W   = 2,
  parameter int MAX_RINSE = 3,
  parameter int FILL_S    = 4,
  parameter int DRAIN_S   = 3,
  parameter int SPIN_S    = 5,
  parameter int BEEP_S    = 3
) (
  input  logic               clk,
  input  logic               resetBtn,
  input  logic               tick,
  input  logic               runBtn,
  input  logic               doorOpen,
  input  logic [1:0]         waterLevel,
  input  logic [RINSE_W-1:0] rinseCount,
  input  logic [TIME_W-1:0]  washTime,
  input  logic [TIME_W-1:0]  rinseTime,
  output logic [2:0]         phase,
  output logic               paused,
  output logic [TIME_W-1:0]  remaining,
  output logic [RINSE_W-1:0] rinseLeft,
  output logic               valveIn,
  output logic               valveOut,
  output logic               motorWash,
  output logic               motorSpin,
  output logic               doorLock,
  output logic               beep,
  output logic               done
);

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_FILL  = 3'd1;
  localparam logic [2:0] PH_WASH  = 3'd2;
  localparam logic [2:0] PH_RINSE = 3'd3;
  localparam logic [2:0] PH_DRAIN = 3'd4;
  localparam logic [2:0] PH_SPIN  = 3'd5;
  localparam logic [2:0] PH_DONE  = 3'd6;

  localparam int PW = TIME_W + 2;
  localparam logic [PW-1:0] SAT_MAX  = {2'b00, {TIME_W{1'b1}}};
  localparam logic [PW-1:0] FILL_K   = PW'(FILL_S);
  localparam logic [PW-1:0] DRAIN_K  = PW'(DRAIN_S);
  localparam logic [PW-1:0] SPIN_K   = PW'(SPIN_S);
  localparam logic [PW-1:0] BEEP_K   = PW'(BEEP_S);
  localparam logic [RINSE_W-1:0] RINSE_CAP = RINSE_W'(MAX_RINSE);

  function automatic logic [TIME_W-1:0] sat_time(input logic [PW-1:0] v);
    sat_time = (v > SAT_MAX) ? SAT_MAX[TIME_W-1:0] : v[TIME_W-1:0];
  endfunction

  // Program state and the configuration latched at start
  logic [2:0]         r_phase;
  logic               r_paused;
  logic [TIME_W-1:0]  r_remaining;
  logic [RINSE_W-1:0] r_rinse_left;
  logic               r_wash_done;
  logic               r_done;
  logic [1:0]         r_level;
  logic [TIME_W-1:0]  r_wash_time;
  logic [TIME_W-1:0]  r_rinse_time;

  logic [1:0]         w_start_level;
  logic [RINSE_W-1:0] w_start_rinse;
  logic [TIME_W-1:0]  w_start_fill;
  logic               w_start;
  logic               w_running;
  logic               w_active;
  logic               w_expire;
  logic               w_advance;
  logic               w_countdown;
  logic [2:0]         w_next_phase;
  logic [RINSE_W-1:0] w_next_rinse;
  logic               w_next_wash_done;
  logic [TIME_W-1:0]  w_next_dur;

  assign w_start_level = (waterLevel == 2'd0) ? 2'd1 : waterLevel;
  assign w_start_rinse = (int'(rinseCount) > MAX_RINSE) ? RINSE_CAP : rinseCount;
  assign w_start_fill  = sat_time(FILL_K * {{TIME_W{1'b0}}, w_start_level});

  // runBtn and tick are single-cycle pulses sampled on the clock edge; there is no
  // backpressure. A pause/resume request always consumes a coincident tick.
  assign w_start   = (r_phase == PH_IDLE) && runBtn && !doorOpen;
  assign w_running = (r_phase >= PH_FILL) && (r_phase <= PH_SPIN);
  assign w_active  = (r_phase == PH_DONE) ||
                     (w_running && !r_paused && !runBtn && !doorOpen);
  // A zero-length phase expires without waiting for a tick
  assign w_expire    = (r_remaining == '0) || (tick && (r_remaining == TIME_W'(1)));
  assign w_advance   = w_active && w_expire;
  assign w_countdown = w_active && !w_expire && tick;

  always_comb begin
    w_next_phase     = PH_IDLE;
    w_next_rinse     = r_rinse_left;
    w_next_wash_done = r_wash_done;
    case (r_phase)
      PH_FILL:  w_next_phase = r_wash_done ? PH_RINSE : PH_WASH;
      PH_WASH: begin
        w_next_phase     = PH_DRAIN;
        w_next_wash_done = 1'b1;
      end
      PH_RINSE: w_next_phase = PH_DRAIN;
      PH_DRAIN: w_next_phase = PH_SPIN;
      PH_SPIN: begin
        if (r_rinse_left != '0) begin
          w_next_phase = PH_FILL;
          w_next_rinse = r_rinse_left - RINSE_W'(1);
        end else begin
          w_next_phase = PH_DONE;
        end
      end
      default:  w_next_phase = PH_IDLE;
    endcase
  end

  always_comb begin
    w_next_dur = '0;
    case (w_next_phase)
      PH_FILL:  w_next_dur = sat_time(FILL_K * {{TIME_W{1'b0}}, r_level});
      PH_WASH:  w_next_dur = r_wash_time;
      PH_RINSE: w_next_dur = r_rinse_time;
      PH_DRAIN: w_next_dur = sat_time(DRAIN_K * {{TIME_W{1'b0}}, r_level});
      PH_SPIN:  w_next_dur = sat_time(SPIN_K);
      PH_DONE:  w_next_dur = sat_time(BEEP_K);
      default:  w_next_dur = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetBtn) begin
      r_phase      <= PH_IDLE;
      r_paused     <= 1'b0;
      r_remaining  <= '0;
      r_rinse_left <= '0;
      r_wash_done  <= 1'b0;
      r_done       <= 1'b0;
      r_level      <= 2'd1;
      r_wash_time  <= '0;
      r_rinse_time <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_level      <= w_start_level;
        r_wash_time  <= washTime;
        r_rinse_time <= rinseTime;
        r_rinse_left <= w_start_rinse;
        r_wash_done  <= 1'b0;
        r_paused     <= 1'b0;
        r_phase      <= PH_FILL;
        r_remaining  <= w_start_fill;
      end else if (w_running && r_paused) begin
        if (runBtn && !doorOpen) r_paused <= 1'b0;
      end else if (w_running && (runBtn || doorOpen)) begin
        r_paused <= 1'b1;
      end else if (w_advance) begin
        r_phase      <= w_next_phase;
        r_remaining  <= w_next_dur;
        r_rinse_left <= w_next_rinse;
        r_wash_done  <= w_next_wash_done;
        r_done       <= (w_next_phase == PH_DONE);
      end else if (w_countdown) begin
        r_remaining <= r_remaining - TIME_W'(1);
      end
    end
  end

  assign phase     = r_phase;
  assign paused    = r_paused;
  assign remaining = r_remaining;
  assign rinseLeft = r_rinse_left;
  assign done      = r_done;
  assign beep      = (r_phase == PH_DONE);
  assign doorLock  = w_running;
  assign valveIn   = !r_paused && (r_phase == PH_FILL);
  assign motorWash = !r_paused && ((r_phase == PH_WASH) || (r_phase == PH_RINSE));
  assign valveOut  = !r_paused && ((r_phase == PH_DRAIN) || (r_phase == PH_SPIN));
  assign motorSpin = !r_paused && (r_phase == PH_SPIN);

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: a program-list reference model compared every cycle,
// directed scenarios with literal pins, then randomized traffic.
module tb_wash_sequencer;
  localparam int TIME_W = 8;
  localparam int RINSE_W = 2;
  localparam int MAX_RINSE = 2;
  localparam int FILL_S = 4;
  localparam int DRAIN_S = 3;
  localparam int SPIN_S = 5;
  localparam int BEEP_S = 3;
  localparam int TMAX = (1 << TIME_W) - 1;

  logic clk = 1'b0;
  logic resetBtn = 1'b0;
  logic tick = 1'b0;
  logic runBtn = 1'b0;
  logic doorOpen = 1'b0;
  logic [1:0] waterLevel = 2'd1;
  logic [RINSE_W-1:0] rinseCount = '0;
  logic [TIME_W-1:0] washTime = '0;
  logic [TIME_W-1:0] rinseTime = '0;
  logic [2:0] phase;
  logic paused;
  logic [TIME_W-1:0] remaining;
  logic [RINSE_W-1:0] rinseLeft;
  logic valveIn, valveOut, motorWash, motorSpin, doorLock, beep, done;

  wash_sequencer #(
    .TIME_W(TIME_W), .RINSE_W(RINSE_W), .MAX_RINSE(MAX_RINSE),
    .FILL_S(FILL_S), .DRAIN_S(DRAIN_S), .SPIN_S(SPIN_S), .BEEP_S(BEEP_S)
  ) dut (
    .clk(clk), .resetBtn(resetBtn), .tick(tick), .runBtn(runBtn), .doorOpen(doorOpen),
    .waterLevel(waterLevel), .rinseCount(rinseCount), .washTime(washTime),
    .rinseTime(rinseTime), .phase(phase), .paused(paused), .remaining(remaining),
    .rinseLeft(rinseLeft), .valveIn(valveIn), .valveOut(valveOut),
    .motorWash(motorWash), .motorSpin(motorSpin), .doorLock(doorLock),
    .beep(beep), .done(done)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int done_cnt = 0;

  // Reference model: the whole program is expanded into a list of steps at start
  typedef struct {
    int ph;
    int dur;
    int rinse;
  } step_t;
  step_t plan[$];
  bit m_active = 1'b0;
  bit m_paused = 1'b0;
  bit m_done = 1'b0;
  int m_idx = 0;
  int m_rem = 0;
  int m_ticks = 0;

  function automatic int sat(input int v);
    return (v > TMAX) ? TMAX : v;
  endfunction

  function automatic void add_step(input int ph, input int dur, input int rinse);
    step_t s;
    s.ph = ph;
    s.dur = dur;
    s.rinse = rinse;
    plan.push_back(s);
  endfunction

  function automatic void build_plan();
    int lv;
    int rc;
    lv = (waterLevel == 0) ? 1 : int'(waterLevel);
    rc = (int'(rinseCount) > MAX_RINSE) ? MAX_RINSE : int'(rinseCount);
    plan.delete();
    add_step(1, sat(FILL_S * lv), rc);
    add_step(2, int'(washTime), rc);
    add_step(4, sat(DRAIN_S * lv), rc);
    add_step(5, sat(SPIN_S), rc);
    for (int k = rc - 1; k >= 0; k--) begin
      add_step(1, sat(FILL_S * lv), k);
      add_step(3, int'(rinseTime), k);
      add_step(4, sat(DRAIN_S * lv), k);
      add_step(5, sat(SPIN_S), k);
    end
    add_step(6, sat(BEEP_S), 0);
  endfunction

  function automatic void step_next();
    m_idx++;
    if (m_idx >= plan.size()) begin
      m_active = 1'b0;
      m_rem = 0;
    end else begin
      m_rem = plan[m_idx].dur;
      if (plan[m_idx].ph == 6) m_done = 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    if (!resetBtn) begin
      m_active = 1'b0;
      m_paused = 1'b0;
      m_rem = 0;
      m_idx = 0;
      plan.delete();
    end else if (!m_active) begin
      if (runBtn && !doorOpen) begin
        build_plan();
        m_idx = 0;
        m_rem = plan[0].dur;
        m_active = 1'b1;
        m_paused = 1'b0;
        m_ticks = 0;
      end
    end else if (plan[m_idx].ph != 6 && m_paused) begin
      if (runBtn && !doorOpen) m_paused = 1'b0;
    end else if (plan[m_idx].ph != 6 && (runBtn || doorOpen)) begin
      m_paused = 1'b1;
    end else if (m_rem == 0) begin
      step_next();
    end else if (tick) begin
      m_ticks++;
      if (m_rem == 1) step_next();
      else m_rem--;
    end
  end

  function automatic logic [20:0] model_vec();
    int ph;
    int rn;
    bit p;
    ph = m_active ? plan[m_idx].ph : 0;
    rn = m_active ? plan[m_idx].rinse : 0;
    p = m_paused;
    return {3'(ph), p, TIME_W'(m_active ? m_rem : 0), RINSE_W'(rn),
            (ph == 1) && !p, (ph == 4 || ph == 5) && !p, (ph == 2 || ph == 3) && !p,
            (ph == 5) && !p, (ph >= 1 && ph <= 5), (ph == 6), m_done};
  endfunction

  // Scoreboard compare: every cycle once reset has been applied
  always @(negedge clk) begin
    if (chk_en) begin
      logic [20:0] act;
      logic [20:0] exp_v;
      act = {phase, paused, remaining, rinseLeft, valveIn, valveOut, motorWash,
             motorSpin, doorLock, beep, done};
      exp_v = model_vec();
      n_checks++;
      if (act !== exp_v) begin
        n_err++;
        $display("FAIL outputs t=%0t got %h expected %h (phase %0d/%0d rem %0d/%0d)",
                 $time, act, exp_v, phase, exp_v[20:18], remaining, exp_v[16:9]);
      end
      if (done) done_cnt++;
    end
  end

  task automatic pin(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic drive(input logic t, input logic r, input logic d);
    @(negedge clk);
    tick = t;
    runBtn = r;
    doorOpen = d;
  endtask

  task automatic tick_until(input int ph, input int rem, input int max_c);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max_c; i++) begin
      @(negedge clk);
      tick = 1'b0;
      runBtn = 1'b0;
      doorOpen = 1'b0;
      if (int'(phase) == ph && int'(remaining) == rem) begin
        found = 1'b1;
        break;
      end
      tick = 1'b1;
    end
    tick = 1'b0;
    n_checks++;
    if (!found) begin
      n_err++;
      $display("FAIL wait_phase got phase %0d rem %0d expected phase %0d rem %0d",
               phase, remaining, ph, rem);
    end
  endtask

  task automatic config_set(input int wl, input int rc, input int wt, input int rt);
    waterLevel = 2'(wl);
    rinseCount = RINSE_W'(rc);
    washTime = TIME_W'(wt);
    rinseTime = TIME_W'(rt);
  endtask

  task automatic start_prog();
    drive(0, 1, 0);
    drive(0, 0, 0);
  endtask

  initial begin
    resetBtn = 1'b0;
    repeat (2) @(negedge clk);
    resetBtn = 1'b1;
    chk_en = 1'b1;
    pin("reset_phase", phase, 0);
    pin("reset_doorlock", doorLock, 0);

    // Full program: L=2, one rinse, 51 ticks in total
    config_set(2, 1, 6, 4);
    done_cnt = 0;
    start_prog();
    pin("start_phase", phase, 1);
    pin("start_remaining", remaining, 8);
    tick_until(0, 0, 200);
    pin("total_ticks", m_ticks, 51);
    pin("done_pulses", done_cnt, 1);

    // Pause and resume in WASH at remaining=3
    start_prog();
    tick_until(2, 3, 100);
    drive(0, 1, 0);
    repeat (3) drive(1, 0, 0);
    drive(0, 0, 0);
    pin("pause_paused", paused, 1);
    pin("pause_motorwash", motorWash, 0);
    pin("pause_doorlock", doorLock, 1);
    pin("pause_remaining", remaining, 3);
    drive(0, 1, 0);
    drive(0, 0, 0);
    pin("resume_paused", paused, 0);
    pin("resume_remaining", remaining, 3);
    tick_until(0, 0, 200);

    // Door interlock during FILL
    start_prog();
    drive(1, 0, 0);
    drive(0, 0, 1);
    drive(0, 0, 1);
    pin("door_paused", paused, 1);
    pin("door_valvein", valveIn, 0);
    drive(0, 1, 1);
    drive(0, 0, 1);
    pin("door_run_ignored", paused, 1);
    drive(0, 0, 0);
    drive(0, 1, 0);
    drive(0, 0, 0);
    pin("door_resume", paused, 0);
    pin("door_valvein_on", valveIn, 1);
    tick_until(0, 0, 200);

    // Edge configuration: level 0, clipped rinse count, zero-length WASH
    config_set(0, 3, 0, 2);
    start_prog();
    pin("level0_fill", remaining, 4);
    pin("rinse_clip", rinseLeft, 2);
    tick_until(2, 0, 50);
    drive(0, 0, 0);
    pin("zero_wash_phase", phase, 4);
    pin("zero_wash_drain", remaining, 3);
    tick_until(0, 0, 300);

    // Reset mid-RINSE, then a restart runs WASH again
    config_set(1, 1, 3, 5);
    start_prog();
    tick_until(3, 2, 200);
    @(negedge clk);
    resetBtn = 1'b0;
    @(negedge clk);
    resetBtn = 1'b1;
    pin("rst_phase", phase, 0);
    pin("rst_remaining", remaining, 0);
    pin("rst_rinseleft", rinseLeft, 0);
    pin("rst_doorlock", doorLock, 0);
    start_prog();
    tick_until(2, 3, 50);
    tick_until(0, 0, 300);

    // runBtn and tick together in SPIN at remaining=2
    start_prog();
    tick_until(5, 2, 100);
    drive(1, 1, 0);
    drive(0, 0, 0);
    pin("spin_pause", paused, 1);
    pin("spin_remaining", remaining, 2);
    drive(0, 1, 0);
    tick_until(0, 0, 200);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      tick = ($urandom_range(0, 1) == 1);
      runBtn = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 24) == 0) doorOpen = ~doorOpen;
      waterLevel = 2'($urandom_range(0, 3));
      rinseCount = RINSE_W'($urandom_range(0, 3));
      washTime = TIME_W'($urandom_range(0, 5));
      rinseTime = TIME_W'($urandom_range(0, 5));
      resetBtn = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    resetBtn = 1'b1;
    tick = 1'b0;
    runBtn = 1'b0;
    doorOpen = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
